dft_peak_detect: RTL and testbench



---
 rtl/dft_pkg.sv | 22 ++
 rtl/dft_bin_power.sv | 22 ++
 rtl/dft_peak_detect.sv | 125 ++++++++++++
 tb/tb_dft_peak_detect.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// Shared constants, FSM state encoding and bin-slice helper for the DFT peak detector.
package dft_pkg;

   localparam int NBINS = 16;
   localparam int BW    = 16;
   localparam int PW    = 2 * BW;
   localparam int TW    = PW + $clog2(NBINS);
   localparam int KW    = $clog2(NBINS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bin k occupies bus[BW*k +: BW], signed two's complement.
   function automatic logic signed [BW-1:0] get_bin(input logic [NBINS*BW-1:0] bus,
                                                     input logic [KW-1:0]       k);
      return $signed(bus[BW*k +: BW]);
   endfunction

endpackage

// File: rtl/dft_bin_power.sv
// Combinational bin power re^2 + im^2; signed BW-bit inputs, unsigned PW-bit result.
module dft_bin_power
   import dft_pkg::*;
(
   input  logic signed [BW-1:0] re,
   input  logic signed [BW-1:0] im,
   output logic        [PW-1:0] pwr
);

   logic signed [PW-1:0] re_ext, im_ext;
   logic signed [PW-1:0] re_sq, im_sq;

   // Each square is at most 2^30, so the unsigned sum peaks at 2^31 and fits PW bits.
   always_comb begin
      re_ext = PW'(re);
      im_ext = PW'(im);
      re_sq  = re_ext * re_ext;
      im_sq  = im_ext * im_ext;
      pwr    = $unsigned(re_sq) + $unsigned(im_sq);
   end

endmodule

// File: rtl/dft_peak_detect.sv
// Latches a 16-bin frame, scans one bin per clock for peak power and total power.
// Build option DFT_PEAK_DC_SKIP_EN excludes bin 0 from the peak search.
module dft_peak_detect
   import dft_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NBINS*BW-1:0]   X,
   input  logic [NBINS*BW-1:0]   Y,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [KW-1:0]         peak_bin,
   output logic [PW-1:0]         peak_pwr,
   output logic [TW-1:0]         total_pwr
);

`ifdef DFT_PEAK_DC_SKIP_EN
   localparam logic [KW-1:0] FIRST_K = KW'(1);
`else
   localparam logic [KW-1:0] FIRST_K = KW'(0);
`endif
   localparam logic [KW-1:0] LAST_K = KW'(NBINS - 1);

   state_t                state;
   logic [KW-1:0]         k;
   logic [NBINS*BW-1:0]   frame_x, frame_y;
   logic [PW-1:0]         run_max;
   logic [KW-1:0]         run_idx;
   logic [TW-1:0]         acc;

   logic signed [BW-1:0]  re, im;
   logic [PW-1:0]         pwr;
   logic                  take;
   logic [PW-1:0]         new_max;
   logic [KW-1:0]         new_idx;
   logic [TW-1:0]         new_acc;
   logic                  accept;

   assign accept = in_valid && in_ready;

   dft_bin_power u_bin_power (
      .re  (re),
      .im  (im),
      .pwr (pwr)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      re      = get_bin(frame_x, k);
      im      = get_bin(frame_y, k);
      // The first candidate bin loads unconditionally; later bins need strictly greater power,
      // so ties keep the lowest index.
      take    = (k == FIRST_K) || ((k > FIRST_K) && (pwr > run_max));
      new_max = take ? pwr : run_max;
      new_idx = take ? k   : run_idx;
      new_acc = acc + TW'(pwr);
   end

   // NOTE: the frame registers are plain data storage and carry no reset; they are only read while
   // scanning, which always follows a fresh load.
   always_ff @(posedge clk) begin
      if (state == IDLE && accept) begin
         frame_x <= X;
         frame_y <= Y;
      end
   end

   // NOTE: all sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         peak_bin  <= '0;
         peak_pwr  <= '0;
         total_pwr <= '0;
         k         <= '0;
         run_max   <= '0;
         run_idx   <= '0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  k        <= '0;
                  run_max  <= '0;
                  run_idx  <= '0;
                  acc      <= '0;
                  in_ready <= 1'b0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               run_max <= new_max;
               run_idx <= new_idx;
               acc     <= new_acc;
               k       <= k + 1'b1;
               if (k == LAST_K) begin
                  peak_bin  <= new_idx;
                  peak_pwr  <= new_max;
                  total_pwr <= new_acc;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dft_peak_detect.sv
// Directed, table-driven bench for dft_peak_detect plus hold and mid-scan reset sequences.
module tb_dft_peak_detect;
   import dft_pkg::*;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_ready, out_valid, out_ready;
   logic [255:0]  x_bus, y_bus;
   logic [3:0]    peak_bin;
   logic [31:0]   peak_pwr;
   logic [35:0]   total_pwr;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string        name;
      logic [255:0] x;
      logic [255:0] y;
      logic [3:0]   bin;
      logic [31:0]  pwr;
      logic [35:0]  tot;
   } vec_t;

   vec_t vecs[6];

`ifdef DFT_PEAK_DC_SKIP_EN
   localparam logic [3:0] ZERO_PEAK = 4'd1;
   localparam logic [3:0] DC_BIN    = 4'd2;
   localparam logic [31:0] DC_PWR   = 32'd100;
`else
   localparam logic [3:0] ZERO_PEAK = 4'd0;
   localparam logic [3:0] DC_BIN    = 4'd0;
   localparam logic [31:0] DC_PWR   = 32'd1000000;
`endif

   always #5 clk = ~clk;

   dft_peak_detect dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .X         (x_bus),
      .Y         (y_bus),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .peak_bin  (peak_bin),
      .peak_pwr  (peak_pwr),
      .total_pwr (total_pwr)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [255:0] put(input logic [255:0] bus, input int k,
                                        input logic signed [15:0] v);
      logic [255:0] b;
      b = bus;
      b[16*k +: 16] = v;
      return b;
   endfunction

   // Offer a frame once in_ready is seen, then scramble X/Y to prove the frame was latched.
   task automatic accept(input logic [255:0] x, input logic [255:0] y);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_wait", in_ready, 1);
      in_valid = 1'b1;
      x_bus    = x;
      y_bus    = y;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      x_bus    = ~x;
      y_bus    = {y[127:0], y[255:128]} ^ 256'h5a5a;
   endtask

   task automatic wait_done(input string name);
      int cyc;
      cyc = 0;
      while (cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (out_valid) break;
      end
      check({name, "_latency"}, cyc, 16);
   endtask

   task automatic check_outputs(input vec_t v);
      check({v.name, "_bin"},      peak_bin,  v.bin);
      check({v.name, "_pwr"},      peak_pwr,  v.pwr);
      check({v.name, "_tot"},      total_pwr, v.tot);
      check({v.name, "_in_ready"}, in_ready,  0);
   endtask

   task automatic handshake(input vec_t v);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({v.name, "_ov_drop"},  out_valid, 0);
      check({v.name, "_ready_up"}, in_ready,  1);
      check({v.name, "_hold_bin"}, peak_bin,  v.bin);
   endtask

   task automatic run_vec(input vec_t v);
      accept(v.x, v.y);
      wait_done(v.name);
      check_outputs(v);
      handshake(v);
   endtask

   initial begin
      logic [255:0] zx, zy;
      int stray;

      zx = '0;
      zy = '0;
      vecs[0] = '{"zero", zx, zy, ZERO_PEAK, 32'd0, 36'd0};
      vecs[1] = '{"bin5", put(zx, 5, 16'sd100), put(zy, 5, -16'sd50), 4'd5, 32'd12500, 36'd12500};
      vecs[2].name = "tie";
      vecs[2].x = zx;
      vecs[2].y = zy;
      for (int i = 0; i < 16; i++) vecs[2].x = put(vecs[2].x, i, 16'sd1);
      vecs[2].x = put(put(vecs[2].x, 3, 16'sd30), 9, 16'sd30);
      vecs[2].y = put(put(zy, 3, 16'sd40), 9, 16'sd40);
      vecs[2].bin = 4'd3;
      vecs[2].pwr = 32'd2500;
      vecs[2].tot = 36'd5014;
      vecs[3] = '{"maxneg", {16{16'h8000}}, {16{16'h8000}}, ZERO_PEAK,
                  32'h8000_0000, 36'h8_0000_0000};
      vecs[4] = '{"lastbin", put(put(zx, 15, -16'sd7), 2, 16'sd5), put(zy, 15, 16'sd3),
                  4'd15, 32'd58, 36'd83};
      vecs[5] = '{"dc", put(put(zx, 0, 16'sd1000), 2, 16'sd10), zy, DC_BIN, DC_PWR, 36'd1000100};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x_bus     = '0;
      y_bus     = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  in_ready,  1);
      check("rst_out_valid", out_valid, 0);
      check("rst_bin",       peak_bin,  0);
      check("rst_pwr",       peak_pwr,  0);
      check("rst_tot",       total_pwr, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Result held for 10 cycles with stray in_valid pulses while downstream stalls.
      accept(vecs[1].x, vecs[1].y);
      wait_done("hold");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         x_bus    = vecs[3].x;
         y_bus    = vecs[3].y;
         @(posedge clk);
         #1;
         check("hold_valid", out_valid, 1);
         check("hold_ready", in_ready,  0);
         check("hold_bin",   peak_bin,  vecs[1].bin);
         check("hold_pwr",   peak_pwr,  vecs[1].pwr);
         check("hold_tot",   total_pwr, vecs[1].tot);
      end
      in_valid = 1'b0;
      handshake(vecs[1]);

      // Reset while bin 7 is being processed discards the frame.
      accept(vecs[2].x, vecs[2].y);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_in_ready",  in_ready,  1);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_bin",       peak_bin,  0);
      check("mid_rst_pwr",       peak_pwr,  0);
      check("mid_rst_tot",       total_pwr, 0);
      stray = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid) stray++;
      end
      check("mid_rst_no_result", stray, 0);
      run_vec(vecs[4]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
